cpu_control_unit: RTL and testbench

Hardwired Moore-style control unit that sequences the existing CPU datapath through instruction fetch (T0-T2) and execute (T3-T6) for register-format ALU, MUL/DIV, unary, NOP and HALT instructions. It drives every datapath control strobe and decodes the IR value fed back from the datapath. A ready handshake with memory governs the fetch read, with a timeout. It replaces hand-sequenced testbench control and sits directly beside the datapath.

---
 rtl/cpu_control_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: hardwired Moore control sequencer for the CPU datapath.
// Fetch runs T0-T2 with a ready/timeout handshake on the memory read, and
// execute runs T3-T6 depending on the instruction class decoded from IR.
// Outputs decode combinationally from the registered state plus IR.

module cpu_control_unit #(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stop,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [12:0] alu_sel,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [2:0]  tstep,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic        mem_timeout
);

    // Opcode map
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b10001;
    localparam logic [4:0] OP_NEG  = 5'b10010;
    localparam logic [4:0] OP_NOT  = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    // Last wait count value that may still see mem_rdy before the fault-halt
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_ALU3    = 3'd0,
        C_MULDIV  = 3'd1,
        C_UNARY   = 3'd2,
        C_NOP     = 3'd3,
        C_HALT    = 3'd4,
        C_ILLEGAL = 3'd5
    } op_class_t;

    // Instruction class selects which execute sequence runs
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:        cls = C_ALU3;
            OP_MUL, OP_DIV:                 cls = C_MULDIV;
            OP_NEG, OP_NOT:                 cls = C_UNARY;
            OP_NOP:                         cls = C_NOP;
            OP_HALT:                        cls = C_HALT;
            default:                        cls = C_ILLEGAL;
        endcase
        return cls;
    endfunction

    // One-hot ALU operation select; zero for opcodes that do not use the ALU
    function automatic logic [12:0] alu_decode(input logic [4:0] op);
        logic [12:0] sel;
        case (op)
            OP_AND:  sel = 13'h0001;
            OP_OR:   sel = 13'h0002;
            OP_ADD:  sel = 13'h0004;
            OP_SUB:  sel = 13'h0008;
            OP_MUL:  sel = 13'h0010;
            OP_DIV:  sel = 13'h0020;
            OP_SHR:  sel = 13'h0040;
            OP_SHRA: sel = 13'h0080;
            OP_SHL:  sel = 13'h0100;
            OP_ROR:  sel = 13'h0200;
            OP_ROL:  sel = 13'h0400;
            OP_NEG:  sel = 13'h0800;
            OP_NOT:  sel = 13'h1000;
            default: sel = 13'h0000;
        endcase
        return sel;
    endfunction

    // Register number to one-hot bus enable
    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        stop_pend_q, stop_pend_d;
    logic        illegal_q, illegal_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic [4:0]  op_s;
    logic [3:0]  ra_s, rb_s, rc_s;
    op_class_t   op_class_s;
    logic [12:0] alu_op_s;
    logic        busy_s;
    state_t      eoi_state_s;
    logic        unused_ir_s;

    assign op_s        = ir[31:27];
    assign ra_s        = ir[26:23];
    assign rb_s        = ir[22:19];
    assign rc_s        = ir[18:15];
    assign op_class_s  = classify(op_s);
    assign alu_op_s    = alu_decode(op_s);
    assign unused_ir_s = ^ir[14:0];

    assign busy_s      = (state_q != S_IDLE) && (state_q != S_HALT);
    // A stop seen now or earlier in this instruction ends the run at the boundary
    assign eoi_state_s = (stop_pend_q || stop) ? S_IDLE : S_T0;

    assign illegal     = illegal_q;
    assign mem_timeout = mem_timeout_q;

    // State, wait counter and sticky flags, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 8'd0;
            stop_pend_q   <= 1'b0;
            illegal_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stop_pend_q   <= stop_pend_d;
            illegal_q     <= illegal_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next-state sequencing, memory wait counting and sticky flag updates
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = 8'd0;
        stop_pend_d   = stop_pend_q;
        illegal_d     = illegal_q;
        mem_timeout_d = mem_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: begin
                if (mem_rdy) begin
                    state_d = S_T2;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = S_HALT;
                    mem_timeout_d = 1'b1;
                end else begin
                    state_d    = S_T1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                case (op_class_s)
                    C_ALU3, C_MULDIV, C_UNARY: state_d = S_T4;
                    C_NOP:                     state_d = eoi_state_s;
                    C_HALT:                    state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                case (op_class_s)
                    C_ALU3, C_MULDIV: state_d = S_T5;
                    default:          state_d = eoi_state_s;
                endcase
            end
            S_T5: begin
                case (op_class_s)
                    C_MULDIV: state_d = S_T6;
                    default:  state_d = eoi_state_s;
                endcase
            end
            S_T6:    state_d = eoi_state_s;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Stop request is remembered until the run actually parks in IDLE
        if (state_d == S_IDLE) begin
            stop_pend_d = 1'b0;
        end else if (busy_s && stop) begin
            stop_pend_d = 1'b1;
        end else begin
            stop_pend_d = stop_pend_q;
        end
    end

    // Datapath strobes and status decoded from the current T-step and IR
    always_comb begin
        Rout     = 16'h0000;
        Rin      = 16'h0000;
        alu_sel  = 13'h0000;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        tstep    = 3'd0;
        busy     = 1'b0;
        halted   = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_T0: begin
                tstep = 3'd0;
                busy  = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                tstep   = 3'd1;
                busy    = 1'b1;
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                // Incremented PC is loaded only once, on the first T1 cycle
                if (wait_cnt_q == 8'd0) begin
                    PCin = 1'b1;
                end else begin
                    PCin = 1'b0;
                end
            end
            S_T2: begin
                tstep  = 3'd2;
                busy   = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                tstep = 3'd3;
                busy  = 1'b1;
                case (op_class_s)
                    C_ALU3: begin
                        Rout = onehot16(rb_s);
                        Yin  = 1'b1;
                    end
                    C_MULDIV: begin
                        Rout = onehot16(ra_s);
                        Yin  = 1'b1;
                    end
                    C_UNARY: begin
                        Rout    = onehot16(rb_s);
                        alu_sel = alu_op_s;
                        Zin     = 1'b1;
                    end
                    default: begin
                        Rout = 16'h0000;
                    end
                endcase
            end
            S_T4: begin
                tstep = 3'd4;
                busy  = 1'b1;
                case (op_class_s)
                    C_ALU3: begin
                        Rout    = onehot16(rc_s);
                        alu_sel = alu_op_s;
                        Zin     = 1'b1;
                    end
                    C_MULDIV: begin
                        Rout    = onehot16(rb_s);
                        alu_sel = alu_op_s;
                        Zin     = 1'b1;
                    end
                    C_UNARY: begin
                        Zlowout = 1'b1;
                        Rin     = onehot16(ra_s);
                    end
                    default: begin
                        Rout = 16'h0000;
                    end
                endcase
            end
            S_T5: begin
                tstep = 3'd5;
                busy  = 1'b1;
                case (op_class_s)
                    C_ALU3: begin
                        Zlowout = 1'b1;
                        Rin     = onehot16(ra_s);
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                        alu_sel = alu_op_s;
                    end
                    default: begin
                        Rin = 16'h0000;
                    end
                endcase
            end
            S_T6: begin
                tstep = 3'd6;
                busy  = 1'b1;
                case (op_class_s)
                    C_MULDIV: begin
                        Zhighout = 1'b1;
                        HIin     = 1'b1;
                    end
                    default: begin
                        HIin = 1'b0;
                    end
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Testbench for cpu_control_unit: directed scenarios plus a randomized
// instruction stream checked against a per-instruction micro-step model.

module tb_cpu_control_unit;

    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic [12:0] alu;
        logic [13:0] strb;
        logic [2:0]  tstep;
        logic        busy;
        logic        halted;
    } obs_t;

    typedef struct packed {
        obs_t        o;
        logic [31:0] ir_v;
        logic        rdy;
        logic        run_v;
        logic        stop_v;
    } rec_t;

    localparam logic [13:0] B_PCOUT  = 14'h2000;
    localparam logic [13:0] B_PCIN   = 14'h1000;
    localparam logic [13:0] B_INCPC  = 14'h0800;
    localparam logic [13:0] B_MARIN  = 14'h0400;
    localparam logic [13:0] B_READ   = 14'h0200;
    localparam logic [13:0] B_MDRIN  = 14'h0100;
    localparam logic [13:0] B_MDROUT = 14'h0080;
    localparam logic [13:0] B_IRIN   = 14'h0040;
    localparam logic [13:0] B_YIN    = 14'h0020;
    localparam logic [13:0] B_ZIN    = 14'h0010;
    localparam logic [13:0] B_ZLOW   = 14'h0008;
    localparam logic [13:0] B_ZHIGH  = 14'h0004;
    localparam logic [13:0] B_HIIN   = 14'h0002;
    localparam logic [13:0] B_LOIN   = 14'h0001;
    localparam logic [13:0] F_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [13:0] F_T1 = B_ZLOW | B_READ | B_MDRIN;
    localparam logic [13:0] F_T2 = B_MDROUT | B_IRIN;

    localparam logic [4:0] LEGAL_OPS [14] = '{
        5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
        5'b01010, 5'b01011, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b11000};

    logic        clk = 1'b0;
    logic        reset, run, stop, mem_rdy;
    logic [31:0] ir;
    logic [15:0] Rout, Rin;
    logic [12:0] alu_sel;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [2:0]  tstep;
    logic        busy, halted, illegal, mem_timeout;
    obs_t        obs_s;

    int n_checks = 0;
    int n_pass   = 0;
    rec_t exp_q[$];

    cpu_control_unit #(.MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .run(run), .stop(stop), .ir(ir), .mem_rdy(mem_rdy),
        .Rout(Rout), .Rin(Rin), .alu_sel(alu_sel),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .tstep(tstep), .busy(busy), .halted(halted), .illegal(illegal),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    assign obs_s = {Rout, Rin, alu_sel, PCout, PCin, IncPC, MARin, Read, MDRin,
                    MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                    tstep, busy, halted};

    function automatic obs_t mk(input logic [2:0] ts, input logic [15:0] ro,
                                input logic [15:0] ri, input logic [12:0] al,
                                input logic [13:0] sb);
        obs_t o;
        o.rout = ro; o.rin = ri; o.alu = al; o.strb = sb;
        o.tstep = ts; o.busy = 1'b1; o.halted = 1'b0;
        return o;
    endfunction

    function automatic obs_t halt_obs();
        obs_t o;
        o = '0;
        o.halted = 1'b1;
        return o;
    endfunction

    // Apply one cycle of inputs at the falling edge, settle before sampling
    task automatic drive(input logic rst_v, input logic [31:0] ir_v, input logic rdy_v,
                         input logic run_v, input logic stop_v);
        @(negedge clk);
        reset = rst_v; ir = ir_v; mem_rdy = rdy_v; run = run_v; stop = stop_v;
        #1;
    endtask

    // Request stop and wait (bounded) until the unit parks in IDLE
    task automatic wait_idle(input logic [31:0] ir_v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, ir_v, 1'b1, 1'b0, 1'b1);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        drive(1'b0, ir_v, 1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [12:0] alu_of(input logic [4:0] op);
        int n;
        case (op)
            5'b00101: n = 0;  5'b00110: n = 1;  5'b00011: n = 2;  5'b00100: n = 3;
            5'b10000: n = 4;  5'b10001: n = 5;  5'b01001: n = 6;  5'b01010: n = 7;
            5'b01011: n = 8;  5'b00111: n = 9;  5'b01000: n = 10; 5'b10010: n = 11;
            5'b10011: n = 12;
            default:  n = -1;
        endcase
        return (n < 0) ? 13'h0000 : (13'h0001 << n);
    endfunction

    function automatic void push(input obs_t o, input logic [31:0] irv, input logic rdy);
        rec_t r;
        r.o = o; r.ir_v = irv; r.rdy = rdy; r.run_v = 1'($urandom); r.stop_v = 1'b0;
        exp_q.push_back(r);
    endfunction

    // Fetch: T0, then waits+1 T1 cycles (ready on the last), then T2; IR is garbage
    function automatic void push_fetch(input int waits);
        push(mk(3'd0, 16'h0, 16'h0, 13'h0, F_T0), $urandom, 1'($urandom));
        for (int k = 0; k <= waits; k++)
            push(mk(3'd1, 16'h0, 16'h0, 13'h0, F_T1 | ((k == 0) ? B_PCIN : 14'h0)),
                 $urandom, 1'(k == waits));
        push(mk(3'd2, 16'h0, 16'h0, 13'h0, F_T2), $urandom, 1'($urandom));
    endfunction

    // Execute micro-steps per instruction class
    function automatic void push_exec(input logic [31:0] instr);
        logic [4:0]  op;
        logic [15:0] a, b, c;
        logic [12:0] al;
        op = instr[31:27];
        a  = 16'h0001 << instr[26:23];
        b  = 16'h0001 << instr[22:19];
        c  = 16'h0001 << instr[18:15];
        al = alu_of(op);
        if (op == 5'b10000 || op == 5'b10001) begin
            push(mk(3'd3, a, 16'h0, 13'h0, B_YIN), instr, 1'($urandom));
            push(mk(3'd4, b, 16'h0, al, B_ZIN), instr, 1'($urandom));
            push(mk(3'd5, 16'h0, 16'h0, al, B_ZLOW | B_LOIN), instr, 1'($urandom));
            push(mk(3'd6, 16'h0, 16'h0, 13'h0, B_ZHIGH | B_HIIN), instr, 1'($urandom));
        end else if (op == 5'b10010 || op == 5'b10011) begin
            push(mk(3'd3, b, 16'h0, al, B_ZIN), instr, 1'($urandom));
            push(mk(3'd4, 16'h0, a, 13'h0, B_ZLOW), instr, 1'($urandom));
        end else if (op == 5'b11000) begin
            push(mk(3'd3, 16'h0, 16'h0, 13'h0, 14'h0), instr, 1'($urandom));
        end else begin
            push(mk(3'd3, b, 16'h0, 13'h0, B_YIN), instr, 1'($urandom));
            push(mk(3'd4, c, 16'h0, al, B_ZIN), instr, 1'($urandom));
            push(mk(3'd5, 16'h0, a, 13'h0, B_ZLOW), instr, 1'($urandom));
        end
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_s !== '0) $display("FAIL reset_outputs: got %h want %h", obs_s, 64'h0);
        else n_pass++;
        n_checks++;
        if (illegal !== 1'b0 || mem_timeout !== 1'b0)
            $display("FAIL reset_flags: got illegal=%b timeout=%b want 0 0", illegal, mem_timeout);
        else n_pass++;
    endtask

    task automatic test_mul();
        obs_t e [9];
        bit ok;
        e[0] = '0;
        e[1] = mk(3'd0, 16'h0, 16'h0, 13'h0, F_T0);
        e[2] = mk(3'd1, 16'h0, 16'h0, 13'h0, F_T1 | B_PCIN);
        e[3] = mk(3'd2, 16'h0, 16'h0, 13'h0, F_T2);
        e[4] = mk(3'd3, 16'h0004, 16'h0, 13'h0, B_YIN);
        e[5] = mk(3'd4, 16'h0040, 16'h0, 13'h0010, B_ZIN);
        e[6] = mk(3'd5, 16'h0, 16'h0, 13'h0010, B_ZLOW | B_LOIN);
        e[7] = mk(3'd6, 16'h0, 16'h0, 13'h0, B_ZHIGH | B_HIIN);
        e[8] = mk(3'd0, 16'h0, 16'h0, 13'h0, F_T0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 32'h81300000, 1'b1, 1'(i == 0), 1'b0);
            n_checks++;
            if (obs_s !== e[i]) $display("FAIL mul cyc%0d: got %h want %h", i, obs_s, e[i]);
            else n_pass++;
        end
        wait_idle(32'h81300000, ok);
        n_checks++;
        if (!ok || obs_s !== '0) $display("FAIL mul_to_idle: got ok=%b %h want ok=1 0", ok, obs_s);
        else n_pass++;
    endtask

    task automatic test_add_stop();
        obs_t e [10];
        bit ok;
        e[0] = '0;
        e[1] = mk(3'd0, 16'h0, 16'h0, 13'h0, F_T0);
        e[2] = mk(3'd1, 16'h0, 16'h0, 13'h0, F_T1 | B_PCIN);
        e[3] = mk(3'd2, 16'h0, 16'h0, 13'h0, F_T2);
        e[4] = mk(3'd3, 16'h0004, 16'h0, 13'h0, B_YIN);
        e[5] = mk(3'd4, 16'h0008, 16'h0, 13'h0004, B_ZIN);
        e[6] = mk(3'd5, 16'h0, 16'h0002, 13'h0, B_ZLOW);
        e[7] = '0;
        e[8] = '0;
        e[9] = mk(3'd0, 16'h0, 16'h0, 13'h0, F_T0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h18918000, 1'b1, 1'(i == 0 || i == 8), 1'(i == 5));
            n_checks++;
            if (obs_s !== e[i]) $display("FAIL add_stop cyc%0d: got %h want %h", i, obs_s, e[i]);
            else n_pass++;
        end
        wait_idle(32'h18918000, ok);
        n_checks++;
        if (!ok) $display("FAIL add_stop_idle: got ok=%b want 1", ok);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        obs_t e [9];
        e[0] = '0;
        e[1] = mk(3'd0, 16'h0, 16'h0, 13'h0, F_T0);
        e[2] = mk(3'd1, 16'h0, 16'h0, 13'h0, F_T1 | B_PCIN);
        e[3] = mk(3'd1, 16'h0, 16'h0, 13'h0, F_T1);
        e[4] = mk(3'd1, 16'h0, 16'h0, 13'h0, F_T1);
        e[5] = mk(3'd1, 16'h0, 16'h0, 13'h0, F_T1);
        e[6] = mk(3'd2, 16'h0, 16'h0, 13'h0, F_T2);
        e[7] = mk(3'd3, 16'h0, 16'h0, 13'h0, 14'h0);
        e[8] = '0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 32'hC0000000, 1'(i == 5), 1'(i == 0), 1'(i == 7));
            n_checks++;
            if (obs_s !== e[i]) $display("FAIL mem_wait cyc%0d: got %h want %h", i, obs_s, e[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        obs_t e [17];
        bit ok;
        e[0]  = '0;
        e[1]  = mk(3'd0, 16'h0, 16'h0, 13'h0, F_T0);
        e[2]  = mk(3'd1, 16'h0, 16'h0, 13'h0, F_T1 | B_PCIN);
        e[3]  = mk(3'd2, 16'h0, 16'h0, 13'h0, F_T2);
        e[4]  = mk(3'd3, 16'h0004, 16'h0, 13'h0, B_YIN);
        e[5]  = mk(3'd4, 16'h0040, 16'h0, 13'h0010, B_ZIN);
        e[6]  = '0;
        e[7]  = '0;
        e[8]  = '0;
        e[9]  = e[1];
        e[10] = e[2];
        e[11] = e[3];
        e[12] = e[4];
        e[13] = e[5];
        e[14] = mk(3'd5, 16'h0, 16'h0, 13'h0010, B_ZLOW | B_LOIN);
        e[15] = mk(3'd6, 16'h0, 16'h0, 13'h0, B_ZHIGH | B_HIIN);
        e[16] = e[1];
        for (int i = 0; i < 17; i++) begin
            drive(1'(i == 5 || i == 6), 32'h81300000, 1'b1, 1'(i == 0 || i == 8), 1'(i == 4));
            n_checks++;
            if (obs_s !== e[i]) $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs_s, e[i]);
            else n_pass++;
        end
        wait_idle(32'h81300000, ok);
        n_checks++;
        if (!ok) $display("FAIL reset_mid_idle: got ok=%b want 1", ok);
        else n_pass++;
    endtask

    task automatic test_random();
        rec_t r;
        int last_start, stop_at, waits;
        logic [31:0] instr;
        exp_q.delete();
        r.o = '0; r.ir_v = $urandom; r.rdy = 1'b0; r.run_v = 1'b1; r.stop_v = 1'b0;
        exp_q.push_back(r);
        last_start = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 29) last_start = exp_q.size();
            waits = (k == 0) ? 7 : int'($urandom_range(7, 0));
            instr = {LEGAL_OPS[$urandom_range(13, 0)], 27'($urandom)};
            push_fetch(waits);
            push_exec(instr);
        end
        stop_at = last_start + int'($urandom_range(exp_q.size() - 1 - last_start, 0));
        r = exp_q[stop_at];
        r.stop_v = 1'b1;
        exp_q[stop_at] = r;
        r.o = '0; r.ir_v = $urandom; r.rdy = 1'b0; r.run_v = 1'b0; r.stop_v = 1'b0;
        exp_q.push_back(r);
        foreach (exp_q[i]) begin
            drive(1'b0, exp_q[i].ir_v, exp_q[i].rdy, exp_q[i].run_v, exp_q[i].stop_v);
            n_checks++;
            if (obs_s !== exp_q[i].o)
                $display("FAIL random cyc%0d ir=%h: got %h want %h", i, exp_q[i].ir_v, obs_s, exp_q[i].o);
            else n_pass++;
        end
        n_checks++;
        if (illegal !== 1'b0 || mem_timeout !== 1'b0)
            $display("FAIL random_flags: got illegal=%b timeout=%b want 0 0", illegal, mem_timeout);
        else n_pass++;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'hC0000000, 1'b0, 1'(i == 0), 1'b0);
            n_checks++;
            if (i >= 2 && obs_s !== mk(3'd1, 16'h0, 16'h0, 13'h0, F_T1 | ((i == 2) ? B_PCIN : 14'h0)))
                $display("FAIL timeout_wait cyc%0d: got %h want T1", i, obs_s);
            else if (i == 1 && obs_s !== mk(3'd0, 16'h0, 16'h0, 13'h0, F_T0))
                $display("FAIL timeout_t0: got %h want T0", obs_s);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'hC0000000, 1'(i > 0), 1'(i > 0), 1'b0);
            n_checks++;
            if (obs_s !== halt_obs() || mem_timeout !== 1'b1 || illegal !== 1'b0)
                $display("FAIL timeout_halt cyc%0d: got %h to=%b ill=%b want %h 1 0",
                         i, obs_s, mem_timeout, illegal, halt_obs());
            else n_pass++;
        end
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_s !== '0 || mem_timeout !== 1'b0)
            $display("FAIL timeout_clear: got %h to=%b want 0 0", obs_s, mem_timeout);
        else n_pass++;
    endtask

    task automatic test_stop_instr(input logic [31:0] instr, input logic want_ill);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, instr, 1'b1, 1'(i == 0), 1'b0);
            if (i == 4) begin
                n_checks++;
                if (obs_s !== mk(3'd3, 16'h0, 16'h0, 13'h0, 14'h0) || illegal !== 1'b0)
                    $display("FAIL haltop_t3 ir=%h: got %h ill=%b want T3 0", instr, obs_s, illegal);
                else n_pass++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, instr, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (obs_s !== halt_obs() || illegal !== want_ill || mem_timeout !== 1'b0)
                $display("FAIL haltop ir=%h cyc%0d: got %h ill=%b want %h ill=%b",
                         instr, i, obs_s, illegal, halt_obs(), want_ill);
            else n_pass++;
        end
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_s !== '0 || illegal !== 1'b0)
            $display("FAIL haltop_clear ir=%h: got %h ill=%b want 0 0", instr, obs_s, illegal);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; stop = 1'b0; mem_rdy = 1'b0; ir = 32'h0;
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_mul();
        test_add_stop();
        test_mem_wait();
        test_reset_mid();
        test_random();
        test_timeout();
        test_stop_instr(32'hF8000000, 1'b1);
        test_stop_instr(32'hC8000000, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
